// File: rtl/muldiv_seq.sv
// Iterative 64-bit MUL/DIV/DIVU/REM/REMU unit for the EX stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle for 64 cycles; divide-by-zero, signed overflow and unsupported
// opcodes complete through a one-cycle fast path.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start_i, op_i                request valid, funct3 opcode
//   rs1_data_i, rs2_data_i       operands
//   rd_addr_i                    destination register of the request
//   flush_i                      pipeline flush, aborts the operation
//   stall_o                      holds IF/ID/EX while an operation is running
//   busy_o                       high in CALC and DONE
//   done_o, wreg_o               one-cycle result-valid / register-write pulse
//   result_o, rd_addr_o          result and destination, held until next start
module muldiv_seq #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            wreg_o
);

  localparam int unsigned CW = 7;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;   // product accumulator / partial remainder
  logic [XLEN-1:0] opa_q;   // multiplicand / dividend shifting into quotient
  logic [XLEN-1:0] opb_q;   // multiplier / divisor
  logic            mul_q;
  logic            rem_q;
  logic            neg_q_q; // negate quotient at the end
  logic            neg_r_q; // negate remainder at the end
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_addr_q;

  // Request decode
  logic            accept;
  logic            is_mul_i;
  logic            is_div_i;
  logic            signed_i;
  logic            div_zero;
  logic            div_ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;

  assign accept   = (state_q == IDLE) && start_i && !flush_i && !rst;
  assign is_mul_i = (op_i == 3'b000);
  assign is_div_i = op_i[2];
  assign signed_i = !op_i[0];
  assign div_zero = (rs2_data_i == '0);
  assign div_ovf  = signed_i && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (rs2_data_i == '1);
  assign fast     = !is_mul_i && !(is_div_i && !div_zero && !div_ovf);
  assign rs1_neg  = signed_i && rs1_data_i[XLEN-1];
  assign rs2_neg  = signed_i && rs2_data_i[XLEN-1];
  assign rs1_mag  = rs1_neg ? (~rs1_data_i + XLEN'(1)) : rs1_data_i;
  assign rs2_mag  = rs2_neg ? (~rs2_data_i + XLEN'(1)) : rs2_data_i;

  // Fast-path result: unsupported op, divide by zero, signed overflow
  always_comb begin
    fast_res = '0;
    if (is_div_i) begin
      if (div_zero) begin
        fast_res = op_i[1] ? rs1_data_i : '1;
      end else if (div_ovf) begin
        fast_res = op_i[1] ? '0 : rs1_data_i;
      end
    end
  end

  // One iteration of the selected algorithm
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] opa_d;
  logic [XLEN-1:0] opb_d;
  logic [XLEN-1:0] final_res;

  always_comb begin
    rem_sh    = {acc_q, opa_q[XLEN-1]};
    rem_diff  = rem_sh - {1'b0, opb_q};
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    final_res = '0;
    if (mul_q) begin
      acc_d     = opb_q[0] ? (acc_q + opa_q) : acc_q;
      opa_d     = {opa_q[XLEN-2:0], 1'b0};
      opb_d     = {1'b0, opb_q[XLEN-1:1]};
      final_res = acc_d;
    end else begin
      // No borrow means the shifted remainder covers the divisor
      if (!rem_diff[XLEN]) begin
        acc_d = rem_diff[XLEN-1:0];
        opa_d = {opa_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[XLEN-1:0];
        opa_d = {opa_q[XLEN-2:0], 1'b0};
      end
      if (rem_q) begin
        final_res = neg_r_q ? (~acc_d + XLEN'(1)) : acc_d;
      end else begin
        final_res = neg_q_q ? (~opa_d + XLEN'(1)) : opa_d;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      mul_q     <= 1'b0;
      rem_q     <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
      rd_addr_q <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= is_mul_i ? rs1_data_i : rs1_mag;
      opb_q     <= is_mul_i ? rs2_data_i : rs2_mag;
      mul_q     <= is_mul_i;
      rem_q     <= op_i[1];
      neg_q_q   <= rs1_neg ^ rs2_neg;
      neg_r_q   <= rs1_neg;
      rd_addr_q <= rd_addr_i;
      if (fast) begin
        result_q <= fast_res;
      end
    end else if ((state_q == CALC) && !flush_i) begin
      cnt_q <= cnt_q + CW'(1);
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      if (cnt_q == LAST_ITER) begin
        result_q <= final_res;
      end
    end
  end

  // Control outputs are decoded from the state register; done is masked
  // by a same-cycle flush so a killed result never writes rd.
  assign stall_o   = accept || (state_q == CALC);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE) && !flush_i;
  assign wreg_o    = done_o;
  assign result_o  = result_q;
  assign rd_addr_o = rd_addr_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width; only 64 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, request valid; sampled only in IDLE.
REQ-005 SHALL have port op_i, input, 3, funct3 code: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_data_i, input, 64, multiplicand or dividend; forwarded value already resolved upstream.
REQ-007 SHALL have port rs2_data_i, input, 64, multiplier or divisor.
REQ-008 SHALL have port rd_addr_i, input, 5, destination register of the request.
REQ-009 SHALL have port flush_i, input, 1, pipeline flush from branch_flag; aborts the operation.
REQ-010 SHALL have port stall_o, output, 1, holds IF/ID/EX pipeline registers while high.
REQ-011 SHALL have port busy_o, output, 1, high in CALC and DONE.
REQ-012 SHALL have port done_o, output, 1, one-cycle pulse when result_o is valid.
REQ-013 SHALL have port result_o, output, 64, operation result.
REQ-014 SHALL have port rd_addr_o, output, 5, latched destination register.
REQ-015 SHALL have port wreg_o, output, 1, write enable for rd, equal to done_o.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 IDLE: start_i=1 and flush_i=0 SHALL latch operands, op and rd_addr_i, then go to CALC (normal) or DONE (fast path).
REQ-018 stall_o SHALL equal (IDLE and start_i and !flush_i) or CALC; it SHALL be 0 in DONE so the pipeline advances with the result.
REQ-019 CALC SHALL run exactly 64 iterations using a 7-bit counter, one shift-add (MUL) or one restoring shift-subtract (div/rem) per cycle, then go to DONE.
REQ-020 Normal latency SHALL be as follows: start accepted in cycle 0, CALC in cycles 1-64, done_o high in cycle 65, IDLE in cycle 66.
REQ-021 MUL SHALL return the low 64 bits of rs1*rs2; these bits are identical for signed and unsigned operands.
REQ-022 DIV/REM SHALL operate on absolute values.
REQ-023 For DIV/REM, the quotient SHALL be negated when the operand signs differ.
REQ-024 For DIV/REM, the remainder SHALL take the dividend's sign.
REQ-025 DIVU/REMU SHALL operate on the raw unsigned operands.
REQ-026 Fast path, divisor==0: DIV/DIVU SHALL return 0xFFFF_FFFF_FFFF_FFFF and REM/REMU SHALL return rs1; done_o SHALL be in cycle 1.
REQ-027 Fast path, DIV/REM with rs1=0x8000_0000_0000_0000 and rs2=-1: DIV SHALL return rs1 and REM SHALL return 0; done_o SHALL be in cycle 1.
REQ-028 An unsupported op_i SHALL take the fast path with result 0, done_o in cycle 1 and wreg_o=1.
REQ-029 DONE SHALL last exactly one cycle and return to IDLE.
REQ-030 result_o and rd_addr_o SHALL hold their values until the next accepted start.
REQ-031 start_i outside IDLE SHALL be ignored (no queueing).
REQ-032 flush_i in CALC or DONE SHALL force IDLE next cycle with no done_o/wreg_o pulse (in DONE, the same-cycle done_o is suppressed).
REQ-033 flush_i together with start_i in IDLE SHALL win: nothing is accepted and stall_o=0.
REQ-034 After a flush, a new start SHALL be accepted on the first IDLE cycle.

Reset
REQ-035 rst=1 SHALL force IDLE, counter 0, result_o 0, rd_addr_o 0, done_o 0, wreg_o 0, busy_o 0 and stall_o 0 on the next edge.
REQ-036 Reset SHALL take effect from any state, including mid-CALC; the partial result SHALL be discarded.

Verification
REQ-037 MUL 7 * -3, rd=5 -> stall_o high for cycles 0-64; done_o/wreg_o in cycle 65; result 0xFFFF_FFFF_FFFF_FFEB; rd_addr_o 5.
REQ-038 DIV -20/3 -> 0xFFFF_FFFF_FFFF_FFFA in cycle 65; REM -20%3 -> 0xFFFF_FFFF_FFFF_FFFE; DIVU 100/7 -> 14; REMU 100%7 -> 2.
REQ-039 DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF with done_o in cycle 1; REMU 5/0 -> 5 in cycle 1.
REQ-040 DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000 in cycle 1; REM same operands -> 0.
REQ-041 DIV started, flush_i in cycle 30 -> IDLE in cycle 31, no done_o; MUL started in cycle 31 -> done_o in cycle 96.
REQ-042 rst in cycle 40 of a DIV -> all outputs 0 next cycle; start_i held during rst is not accepted.
